astropix_frame_unpacker_av1: RTL and testbench



---
 rtl/astep_frame_pkg.sv | 30 +++
 rtl/frame_record_reg.sv | 39 +++
 rtl/astropix_frame_unpacker_av1.sv | 205 ++++++++++++++++++++
 tb/tb_astropix_frame_unpacker_av1.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/astep_frame_pkg.sv
// Purpose: shared layer-frame format definitions (reader and framing transmitter).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: frame length limits, error-code enum frame_err_t, parallel record frame_record_t.
package astep_frame_pkg;

  // LENGTH byte counts LAYER_ID + HDR + TS[3:0] + N payload bytes.
  localparam int HEADER_OVERHEAD = 6;
  localparam int FRAME_LEN_MIN   = 6;
  localparam int FRAME_LEN_MAX   = 13;
  localparam int PAYLOAD_BYTES   = 7;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_BAD_LEN      = 3'd1,
    ERR_BAD_LAYER    = 3'd2,
    ERR_LEN_MISMATCH = 3'd3,
    ERR_EARLY_LAST   = 3'd4,
    ERR_MISSING_LAST = 3'd5
  } frame_err_t;

  typedef struct packed {
    logic [2:0]                   layer;
    logic [7:0]                   header;
    logic [2:0]                   count;
    logic [8*PAYLOAD_BYTES-1:0]   payload;
    logic [31:0]                  timestamp;
  } frame_record_t;

endpackage

// File: rtl/frame_record_reg.sv
// Purpose: holding register for one parsed frame record with valid/ready output handshake.
// Latency: record visible and o_valid high 1 cycle after i_load.
// Backpressure: holds the record stable while o_valid && !i_ready; clears o_valid on handshake.
// Ports: clk, rst (sync, active-high); i_load/i_rec capture a record; i_ready from consumer;
//        o_valid/o_rec present the held record.
module frame_record_reg
  import astep_frame_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  frame_record_t i_rec,
  input  logic          i_ready,
  output logic          o_valid,
  output frame_record_t o_rec
);

  logic          r_valid;
  frame_record_t r_rec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rec   <= '0;
    end else begin
      if (i_load) begin
        r_rec   <= i_rec;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        // Data is left in place after the handshake; only valid drops.
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_rec   = r_rec;

endmodule

// File: rtl/astropix_frame_unpacker_av1.sv
// Purpose: parses AXIS byte-stream layer frames into parallel records; drops malformed frames.
// Latency: record valid and stat_frame_ok 1 cycle after the TS3 beat; errors pulse 1 cycle after the bad beat.
// Backpressure: s_axis_tready low while a record waits (EMIT) and in the cycle after a TS3 beat.
// Ports: clk, rst (sync, active-high); s_axis_* byte stream in; m_rec_* record out (valid/ready);
//        stat_frame_ok / stat_frame_error / stat_error_code status pulses.
module astropix_frame_unpacker_av1
  import astep_frame_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_LAYERS  = 3,
  parameter int MAX_PAYLOAD = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic                     m_rec_valid,
  input  logic                     m_rec_ready,
  output logic [2:0]               m_rec_layer,
  output logic [7:0]               m_rec_header,
  output logic [2:0]               m_rec_count,
  output logic [8*MAX_PAYLOAD-1:0] m_rec_payload,
  output logic [31:0]              m_rec_timestamp,
  output logic                     stat_frame_ok,
  output logic                     stat_frame_error,
  output logic [2:0]               stat_error_code
);

  typedef enum logic [3:0] {
    S_LENGTH, S_LAYER, S_HDR, S_PAYLOAD,
    S_TS0, S_TS1, S_TS2, S_TS3,
    S_EMIT, S_DISCARD
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [7:0]               r_len;
  logic [2:0]               r_layer;
  logic [7:0]               r_hdr;
  logic [2:0]               r_cnt;
  logic [8*PAYLOAD_BYTES-1:0] r_payload;
  logic [23:0]              r_ts;
  logic                     r_ts3_beat;
  logic                     r_ok;
  logic                     r_err_vld;
  frame_err_t               r_err_code;

  logic                     w_beat;
  logic                     w_tready;
  logic                     w_parse;
  logic                     w_load;
  frame_err_t               w_err_code;
  logic [7:0]               w_byte;
  frame_record_t            w_rec_in;
  frame_record_t            w_rec_out;
  logic                     w_rec_vld;

  assign w_byte   = s_axis_tdata[7:0];
  assign w_tready = (r_state != S_EMIT) && !r_ts3_beat;
  assign w_beat   = s_axis_tvalid && w_tready;
  // States in which a tlast means the frame ended before its timestamp was complete.
  assign w_parse  = (r_state != S_TS3) && (r_state != S_EMIT) && (r_state != S_DISCARD);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LENGTH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_code  = ERR_NONE;
    w_load      = 1'b0;
    if (w_beat && s_axis_tlast && w_parse) begin
      // Early tlast outranks every other check on the same beat; the frame is over.
      w_err_code  = ERR_EARLY_LAST;
      w_state_nxt = S_LENGTH;
    end else if (w_beat) begin
      case (r_state)
        S_LENGTH: begin
          if (w_byte < 8'(FRAME_LEN_MIN) || w_byte > 8'(FRAME_LEN_MAX)) begin
            w_err_code  = ERR_BAD_LEN;
            w_state_nxt = S_DISCARD;
          end else begin
            w_state_nxt = S_LAYER;
          end
        end
        S_LAYER: begin
          if (w_byte >= 8'(NUM_LAYERS)) begin
            w_err_code  = ERR_BAD_LAYER;
            w_state_nxt = S_DISCARD;
          end else begin
            w_state_nxt = S_HDR;
          end
        end
        S_HDR: begin
          if (r_len != 8'(HEADER_OVERHEAD) + {5'd0, w_byte[2:0]}) begin
            w_err_code  = ERR_LEN_MISMATCH;
            w_state_nxt = S_DISCARD;
          end else if (w_byte[2:0] == 3'd0) begin
            w_state_nxt = S_TS0;
          end else begin
            w_state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (r_cnt == r_hdr[2:0] - 3'd1) w_state_nxt = S_TS0;
        end
        S_TS0: w_state_nxt = S_TS1;
        S_TS1: w_state_nxt = S_TS2;
        S_TS2: w_state_nxt = S_TS3;
        S_TS3: begin
          if (s_axis_tlast) begin
            w_load      = 1'b1;
            w_state_nxt = S_EMIT;
          end else begin
            w_err_code  = ERR_MISSING_LAST;
            w_state_nxt = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (s_axis_tlast) w_state_nxt = S_LENGTH;
        end
        default: ;
      endcase
    end else if (r_state == S_EMIT && w_rec_vld && m_rec_ready) begin
      w_state_nxt = S_LENGTH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_layer    <= '0;
      r_hdr      <= '0;
      r_cnt      <= '0;
      r_payload  <= '0;
      r_ts       <= '0;
      r_ts3_beat <= 1'b0;
      r_ok       <= 1'b0;
      r_err_vld  <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_ts3_beat <= w_beat && (r_state == S_TS3);
      r_ok       <= w_load;
      r_err_vld  <= (w_err_code != ERR_NONE);
      r_err_code <= w_err_code;
      if (w_beat) begin
        case (r_state)
          S_LENGTH: begin
            r_len <= w_byte;
            // Clearing here keeps payload bytes beyond N at zero in the record.
            if (w_state_nxt == S_LAYER) r_payload <= '0;
          end
          S_LAYER:   r_layer <= w_byte[2:0];
          S_HDR: begin
            r_hdr <= w_byte;
            r_cnt <= 3'd0;
          end
          S_PAYLOAD: begin
            r_payload[8*r_cnt +: 8] <= w_byte;
            r_cnt                   <= r_cnt + 3'd1;
          end
          S_TS0:     r_ts[7:0]   <= w_byte;
          S_TS1:     r_ts[15:8]  <= w_byte;
          S_TS2:     r_ts[23:16] <= w_byte;
          default: ;
        endcase
      end
    end
  end

  // The top timestamp byte is taken straight off the bus on the TS3 beat.
  always_comb begin
    w_rec_in           = '0;
    w_rec_in.layer     = r_layer;
    w_rec_in.header    = r_hdr;
    w_rec_in.count     = r_hdr[2:0];
    w_rec_in.payload   = r_payload;
    w_rec_in.timestamp = {w_byte, r_ts};
  end

  frame_record_reg u_rec_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_rec   (w_rec_in),
    .i_ready (m_rec_ready),
    .o_valid (w_rec_vld),
    .o_rec   (w_rec_out)
  );

  assign s_axis_tready    = w_tready;
  assign m_rec_valid      = w_rec_vld;
  assign m_rec_layer      = w_rec_out.layer;
  assign m_rec_header     = w_rec_out.header;
  assign m_rec_count      = w_rec_out.count;
  assign m_rec_payload    = w_rec_out.payload;
  assign m_rec_timestamp  = w_rec_out.timestamp;
  assign stat_frame_ok    = r_ok;
  assign stat_frame_error = r_err_vld;
  assign stat_error_code  = r_err_code;

endmodule

// File: tb/tb_astropix_frame_unpacker_av1.sv
// Purpose: directed self-checking bench for astropix_frame_unpacker_av1.
// Latency: n/a.
// Backpressure: drives record-side ready holds and honours s_axis_tready.
module tb_astropix_frame_unpacker_av1;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        m_rec_valid;
  logic        m_rec_ready;
  logic [2:0]  m_rec_layer;
  logic [7:0]  m_rec_header;
  logic [2:0]  m_rec_count;
  logic [55:0] m_rec_payload;
  logic [31:0] m_rec_timestamp;
  logic        stat_frame_ok;
  logic        stat_frame_error;
  logic [2:0]  stat_error_code;

  always #5 clk = ~clk;

  astropix_frame_unpacker_av1 dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .m_rec_valid      (m_rec_valid),
    .m_rec_ready      (m_rec_ready),
    .m_rec_layer      (m_rec_layer),
    .m_rec_header     (m_rec_header),
    .m_rec_count      (m_rec_count),
    .m_rec_payload    (m_rec_payload),
    .m_rec_timestamp  (m_rec_timestamp),
    .stat_frame_ok    (stat_frame_ok),
    .stat_frame_error (stat_frame_error),
    .stat_error_code  (stat_error_code)
  );

  typedef struct {
    logic [2:0]  layer;
    logic [7:0]  hdr;
    logic [2:0]  cnt;
    logic [55:0] pl;
    logic [31:0] ts;
  } rec_t;

  rec_t       rec_q[$];
  logic [2:0] err_q[$];
  int         ok_cnt   = 0;
  int         n_checks = 0;
  int         n_pass   = 0;

  // Capture records on handshake and every status pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_rec_valid && m_rec_ready)
        rec_q.push_back('{m_rec_layer, m_rec_header, m_rec_count, m_rec_payload, m_rec_timestamp});
      if (stat_frame_error) err_q.push_back(stat_error_code);
      if (stat_frame_ok) ok_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got running, want finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_tready", 64'(s_axis_tready), 64'(1));
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Bytes are given first-byte-most-significant; n is the byte count.
  task automatic send_frame(input logic [127:0] f, input int n, input logic last_at_end);
    for (int i = 0; i < n; i++)
      send_byte(f[8*(n-1-i) +: 8], last_at_end && (i == n - 1));
  endtask

  task automatic expect_rec(input string tag, input logic [2:0] ly, input logic [7:0] h,
                            input logic [2:0] c, input logic [55:0] p, input logic [31:0] t);
    rec_t r;
    check({tag, "_present"}, 64'(rec_q.size() != 0), 64'(1));
    if (rec_q.size() != 0) begin
      r = rec_q.pop_front();
      check({tag, "_layer"}, 64'(r.layer), 64'(ly));
      check({tag, "_header"}, 64'(r.hdr), 64'(h));
      check({tag, "_count"}, 64'(r.cnt), 64'(c));
      check({tag, "_payload"}, 64'(r.pl), 64'(p));
      check({tag, "_ts"}, 64'(r.ts), 64'(t));
    end
  endtask

  task automatic expect_err(input string tag, input logic [2:0] code);
    check({tag, "_nerr"}, 64'(err_q.size()), 64'(1));
    if (err_q.size() != 0) check({tag, "_code"}, 64'(err_q.pop_front()), 64'(code));
    err_q.delete();
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_norec"}, 64'(rec_q.size()), 64'(0));
    check({tag, "_noerr"}, 64'(err_q.size()), 64'(0));
    rec_q.delete();
    err_q.delete();
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_rec_ready   = 1'b1;
    idle(3);

    // Reset state
    check("rst_tready", 64'(s_axis_tready), 64'(1));
    check("rst_valid", 64'(m_rec_valid), 64'(0));
    check("rst_ok", 64'(stat_frame_ok), 64'(0));
    check("rst_err", 64'(stat_frame_error), 64'(0));
    check("rst_code", 64'(stat_error_code), 64'(0));
    check("rst_payload", 64'(m_rec_payload), 64'(0));
    rst = 1'b0;
    idle(2);

    // Good frame N=1, with latency and pulse-width checks
    send_frame(128'({8'h07, 8'h02, 8'h21, 8'hAB, 8'h78, 8'h56, 8'h34, 8'h12}), 8, 1'b1);
    check("t1_valid_lat", 64'(m_rec_valid), 64'(1));
    check("t1_ok_lat", 64'(stat_frame_ok), 64'(1));
    check("t1_tready_emit", 64'(s_axis_tready), 64'(0));
    idle(1);
    check("t1_ok_pulse", 64'(stat_frame_ok), 64'(0));
    check("t1_valid_drop", 64'(m_rec_valid), 64'(0));
    check("t1_tready_back", 64'(s_axis_tready), 64'(1));
    idle(2);
    expect_rec("t1", 3'd2, 8'h21, 3'd1, 56'hAB, 32'h12345678);
    expect_quiet("t1");

    // N=0 (min length) then N=7 (max length) back-to-back, first record held 5 cycles
    m_rec_ready = 1'b0;
    fork
      begin
        send_frame(128'({8'h06, 8'h00, 8'h08, 8'h44, 8'h33, 8'h22, 8'h11}), 7, 1'b1);
        send_frame(128'({8'h0D, 8'h01, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                         8'hEF, 8'hBE, 8'hAD, 8'hDE}), 14, 1'b1);
      end
      begin
        n = 0;
        while (!m_rec_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("t2_valid_seen", 64'(m_rec_valid), 64'(1));
        for (int k = 0; k < 5; k++) begin
          check("t2_hold_tready", 64'(s_axis_tready), 64'(0));
          check("t2_hold_ts", 64'(m_rec_timestamp), 64'(32'h11223344));
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        m_rec_ready = 1'b1;
      end
    join
    idle(3);
    expect_rec("t2a", 3'd0, 8'h08, 3'd0, 56'h0, 32'h11223344);
    expect_rec("t2b", 3'd1, 8'h0F, 3'd7, 56'h77665544332211, 32'hDEADBEEF);
    expect_quiet("t2");

    // Length mismatch, then a good frame
    send_frame(128'({8'h09, 8'h01, 8'h22, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}), 9, 1'b1);
    idle(3);
    expect_err("t3_mismatch", 3'd3);
    expect_quiet("t3_drop");
    send_frame(128'({8'h08, 8'h01, 8'h22, 8'hC1, 8'hC2, 8'h04, 8'h03, 8'h02, 8'h01}), 9, 1'b1);
    idle(3);
    expect_rec("t3", 3'd1, 8'h22, 3'd2, 56'hC2C1, 32'h01020304);
    expect_quiet("t3");

    // Early tlast on payload byte; next frame follows with no gap
    send_frame(128'({8'h08, 8'h02, 8'h02, 8'h55}), 4, 1'b1);
    send_frame(128'({8'h06, 8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA}), 7, 1'b1);
    idle(3);
    expect_err("t4_early", 3'd4);
    expect_rec("t4", 3'd1, 8'h00, 3'd0, 56'h0, 32'hAABBCCDD);
    expect_quiet("t4");

    // Bad layer, bad lengths (below min / above max), missing tlast, then resync
    send_frame(128'({8'h07, 8'h05, 8'h01, 8'h99, 8'h01, 8'h02, 8'h03, 8'h04}), 8, 1'b1);
    idle(3);
    expect_err("t5_layer", 3'd2);
    send_frame(128'({8'h05, 8'h00, 8'h00, 8'h00}), 4, 1'b1);
    idle(3);
    expect_err("t5_len_lo", 3'd1);
    send_frame(128'({8'h0E, 8'h00, 8'h00}), 3, 1'b1);
    idle(3);
    expect_err("t5_len_hi", 3'd1);
    send_frame(128'({8'h07, 8'h00, 8'h01, 8'h99, 8'h01, 8'h02, 8'h03, 8'h04}), 8, 1'b0);
    send_frame(128'({8'h55, 8'h66}), 2, 1'b1);
    idle(3);
    expect_err("t5_nolast", 3'd5);
    expect_quiet("t5_drop");
    send_frame(128'({8'h07, 8'h01, 8'h41, 8'h5A, 8'h01, 8'h00, 8'h00, 8'h80}), 8, 1'b1);
    idle(3);
    expect_rec("t5", 3'd1, 8'h41, 3'd1, 56'h5A, 32'h80000001);
    expect_quiet("t5");

    // Reset in PAYLOAD
    send_frame(128'({8'h09, 8'h01, 8'h03, 8'hAA}), 4, 1'b0);
    rst = 1'b1;
    idle(1);
    check("t6_tready", 64'(s_axis_tready), 64'(1));
    check("t6_valid", 64'(m_rec_valid), 64'(0));
    check("t6_err", 64'(stat_frame_error), 64'(0));
    check("t6_code", 64'(stat_error_code), 64'(0));
    check("t6_payload", 64'(m_rec_payload), 64'(0));
    check("t6_ts", 64'(m_rec_timestamp), 64'(0));
    rst = 1'b0;
    idle(3);
    expect_quiet("t6_rst");
    send_frame(128'({8'h09, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40}),
               10, 1'b1);
    idle(3);
    expect_rec("t6", 3'd2, 8'h03, 3'd3, 56'h030201, 32'h40302010);
    expect_quiet("t6");

    check("ok_pulses", 64'(ok_cnt), 64'(7));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
